// File: rtl/rv32i_defines.sv
// Shared RV32I front-end definitions: canonical NOP and the prefetch queue entry layout.
package rv32i_defines;

    localparam int RV_XLEN = 32;

    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [31:0]        data;
        logic               filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: entries are allocated at request time and filled in order as responses return.
module fetch_queue
    import rv32i_defines::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc,
    input  logic [RV_XLEN-1:0] alloc_pc,
    input  logic               fill,
    input  logic [31:0]        fill_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CW-1:0]      count
);

    fetch_entry_t entries [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW-1:0] fill_ptr;

    // alloc, fill and pop always touch distinct entries: alloc needs a free slot,
    // fill needs an allocated unfilled slot, pop needs a filled head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '{pc: '0, data: INSTR_NOP, filled: 1'b0};
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            head_ptr <= '0;
            tail_ptr <= '0;
            fill_ptr <= '0;
            count    <= '0;
        end else begin
            if (alloc) begin
                entries[tail_ptr] <= '{pc: alloc_pc, data: INSTR_NOP, filled: 1'b0};
                tail_ptr          <= tail_ptr + PW'(1);
            end
            if (fill) begin
                entries[fill_ptr].data   <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            // Clearing on pop keeps a wrapped-around empty head from looking valid.
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + PW'(1);
            end
            count <= count + CW'(alloc) - CW'(pop);
        end
    end

    assign head = entries[head_ptr];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch front end: PC generation, request issue, in-flight tracking and redirect discard.
module rv32i_fetch_unit
    import rv32i_defines::*;
#(
    parameter int               XLEN             = 32,
    parameter logic [XLEN-1:0]  PC_START_ADDRESS = '0,
    parameter int               DEPTH            = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus_4,
    output logic [XLEN-1:0] PC
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] inflight;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] alloc_cnt;
    logic          req_fire;
    logic          resp_fill;
    logic          pop;
    fetch_entry_t  head;

    // Held low during reset so nothing is requested while the state is being cleared.
    assign imem_req_valid = rst & ena & ~redirect_valid
                          & (alloc_cnt < CW'(DEPTH)) & (inflight < CW'(DEPTH));
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign resp_fill      = imem_resp_valid & ~redirect_valid & (discard_cnt == '0);
    assign pop            = head.filled & instr_ready & ena;
    assign imem_req_addr  = PC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= PC_START_ADDRESS;
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Every request still outstanding after this cycle belongs to the old stream.
                PC          <= redirect_pc;
                discard_cnt <= inflight - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    PC <= PC + XLEN'(4);
                end
                if (imem_resp_valid && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .alloc    (req_fire),
        .alloc_pc (PC),
        .fill     (resp_fill),
        .fill_data(imem_resp_data),
        .pop      (pop),
        .head     (head),
        .count    (alloc_cnt)
    );

    // Outputs read zero whenever the head holds nothing, which also covers reset.
    assign instr_valid     = head.filled;
    assign instr           = head.filled ? head.data : '0;
    assign instr_pc        = head.filled ? head.pc : '0;
    assign instr_pc_plus_4 = head.filled ? (head.pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: in-order memory model, transfer scoreboard, cycle checks.
module tb_rv32i_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus_4;
    logic [31:0] pc;

    logic        hi_req_valid;
    logic [31:0] hi_req_addr;
    logic        hi_instr_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_instr_pc;
    logic [31:0] hi_instr_pc4;
    logic [31:0] hi_pc;

    rv32i_fetch_unit #(.XLEN(32), .PC_START_ADDRESS(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus_4(instr_pc_plus_4), .PC(pc)
    );

    rv32i_fetch_unit #(.XLEN(32), .PC_START_ADDRESS(32'hFFFF_FFF8), .DEPTH(4)) dut_hi (
        .clk(clk), .rst(rst), .ena(ena),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(hi_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(hi_req_addr),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .instr_valid(hi_instr_valid), .instr_ready(instr_ready), .instr(hi_instr),
        .instr_pc(hi_instr_pc), .instr_pc_plus_4(hi_instr_pc4), .PC(hi_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_req_q[$];
    int          mem_lat = 1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model and monitor: respond in order after mem_lat cycles; sample before each posedge.
    always @(negedge clk) begin
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mem_q[0].addr;
            void'(mem_q.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #4;
        if (!rst) begin
            mem_q.delete();
            exp_pc_q.delete();
        end else begin
            if (instr_valid && instr_ready && ena) begin
                if (exp_pc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_transfer: got pc %h expected none (cycle %0d)", instr_pc, cyc);
                end else begin
                    logic [31:0] e;
                    e = exp_pc_q.pop_front();
                    chk("xfer_pc", instr_pc, e);
                    chk("xfer_instr", instr, ~e);
                    chk("xfer_pc_plus_4", instr_pc_plus_4, e + 32'd4);
                end
            end
            if (redirect_valid) begin
                chk("req_during_redirect", {31'b0, imem_req_valid}, 32'h0);
                exp_pc_q.delete();
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                exp_pc_q.push_back(imem_req_addr);
                if (exp_req_q.size() > 0) begin
                    chk("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
            end
        end
        cyc++;
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst = 1'b0; ena = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; mem_lat = lat;
        repeat (2) @(negedge clk);
        exp_req_q.delete();
    endtask

    task automatic push_reqs(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [31:0] a3);
        exp_req_q.push_back(a0); exp_req_q.push_back(a1);
        exp_req_q.push_back(a2); exp_req_q.push_back(a3);
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; imem_req_ready = 1'b1;

        // Streaming with a 1-cycle memory
        do_reset(1);
        push_reqs(32'h0, 32'h4, 32'h8, 32'hC);
        exp_req_q.push_back(32'h10);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b1;
        #4;
        chk("t1_reset_valid", {31'b0, instr_valid}, 32'h0);
        chk("t1_reset_instr", instr, 32'h0);
        chk("t1_reset_pc4", instr_pc_plus_4, 32'h0);
        chk("t1_first_req", {31'b0, imem_req_valid}, 32'h1);
        chk("t1_pc_start", pc, 32'h0);
        @(negedge clk); #4;
        chk("t1_valid_r1", {31'b0, instr_valid}, 32'h0);
        chk("t1_pc_r1", pc, 32'h4);
        @(negedge clk); #4;
        chk("t1_valid_r2", {31'b0, instr_valid}, 32'h1);
        chk("t1_ipc_r2", instr_pc, 32'h0);
        chk("t1_pc4_r2", instr_pc_plus_4, 32'h4);
        @(negedge clk); #4;
        chk("t1_ipc_r3", instr_pc, 32'h4);
        @(negedge clk); #4;
        chk("t1_ipc_r4", instr_pc, 32'h8);
        repeat (4) @(negedge clk);
        chk("t1_req_list", 32'(exp_req_q.size()), 32'h0);

        // Decode stalled: queue fills, then drains in order
        do_reset(1);
        push_reqs(32'h0, 32'h4, 32'h8, 32'hC);
        exp_req_q.push_back(32'h10);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk); #4;
        chk("t2_full_noreq", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_full_pc", pc, 32'h10);
        @(negedge clk); #4;
        chk("t2_full_noreq2", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_head_valid", {31'b0, instr_valid}, 32'h1);
        @(negedge clk); instr_ready = 1'b1; #4;
        chk("t2_noreq_popcycle", {31'b0, imem_req_valid}, 32'h0);
        chk("t2_head_pc", instr_pc, 32'h0);
        @(negedge clk); #4;
        chk("t2_resume_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("t2_resume_addr", imem_req_addr, 32'h10);
        repeat (5) @(negedge clk);
        chk("t2_req_list", 32'(exp_req_q.size()), 32'h0);

        // Redirect with two requests in flight on a 3-cycle memory
        do_reset(3);
        push_reqs(32'h0, 32'h4, 32'h100, 32'h104);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); ena = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk); ena = 1'b1; redirect_valid = 1'b0; #4;
        chk("t3_redirect_addr", imem_req_addr, 32'h100);
        chk("t3_empty_r3", {31'b0, instr_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #4;
            chk("t3_no_stale", {31'b0, instr_valid}, 32'h0);
        end
        @(negedge clk); #4;
        chk("t3_new_valid", {31'b0, instr_valid}, 32'h1);
        chk("t3_new_pc", instr_pc, 32'h100);
        repeat (3) @(negedge clk);
        chk("t3_req_list", 32'(exp_req_q.size()), 32'h0);

        // Redirect in the same cycle as a response and a transfer
        do_reset(1);
        push_reqs(32'h0, 32'h4, 32'h200, 32'h204);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #4;
        chk("t4_xfer_valid", {31'b0, instr_valid}, 32'h1);
        chk("t4_resp_present", {31'b0, imem_resp_valid}, 32'h1);
        chk("t4_xfer_pc", instr_pc, 32'h0);
        @(negedge clk); redirect_valid = 1'b0; #4;
        chk("t4_empty", {31'b0, instr_valid}, 32'h0);
        chk("t4_req_valid", {31'b0, imem_req_valid}, 32'h1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        @(negedge clk);
        @(negedge clk); #4;
        chk("t4_new_valid", {31'b0, instr_valid}, 32'h1);
        chk("t4_new_pc", instr_pc, 32'h200);
        repeat (2) @(negedge clk);
        chk("t4_req_list", 32'(exp_req_q.size()), 32'h0);

        // ena low for five cycles with requests outstanding
        do_reset(3);
        push_reqs(32'h0, 32'h4, 32'h8, 32'hC);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); ena = 1'b0; #4;
            chk("t5_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        chk("t5_held_valid", {31'b0, instr_valid}, 32'h1);
        chk("t5_held_pc", instr_pc, 32'h0);
        chk("t5_pc", pc, 32'hC);
        @(negedge clk); ena = 1'b1; #4;
        chk("t5_resume_addr", imem_req_addr, 32'hC);
        repeat (4) @(negedge clk);
        chk("t5_req_list", 32'(exp_req_q.size()), 32'h0);

        // Address wrap from 0xFFFFFFF8 and an asynchronous reset mid-stream
        do_reset(1);
        @(negedge clk); rst = 1'b1; ena = 1'b1; instr_ready = 1'b1; #4;
        chk("t6_hi_req0", hi_req_addr, 32'hFFFF_FFF8);
        chk("t6_hi_valid0", {31'b0, hi_req_valid}, 32'h1);
        @(negedge clk); #4;
        chk("t6_hi_req1", hi_req_addr, 32'hFFFF_FFFC);
        @(negedge clk); #4;
        chk("t6_hi_req2", hi_req_addr, 32'h0);
        @(negedge clk); #4;
        chk("t6_hi_pc", hi_pc, 32'h4);
        @(negedge clk); #4;
        chk("t6_pre_valid", {31'b0, instr_valid}, 32'h1);
        @(negedge clk); rst = 1'b0; #1;
        chk("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("t6_rst_req", {31'b0, imem_req_valid}, 32'h0);
        chk("t6_rst_instr", instr, 32'h0);
        chk("t6_rst_ipc", instr_pc, 32'h0);
        chk("t6_rst_pc4", instr_pc_plus_4, 32'h0);
        chk("t6_rst_pc", pc, 32'h0);
        chk("t6_rst_hi_pc", hi_pc, 32'hFFFF_FFF8);
        chk("t6_rst_hi_valid", {31'b0, hi_instr_valid}, 32'h0);
        chk("t6_rst_hi_instr", hi_instr | hi_instr_pc | hi_instr_pc4, 32'h0);
        exp_req_q.push_back(32'h0);
        exp_req_q.push_back(32'h4);
        @(negedge clk); rst = 1'b1; #4;
        chk("t6_restart_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_req_list", 32'(exp_req_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
